key_updown_counter: RTL

KEY_UPDOWN_COUNTER -- requirements
Module: key_updown_counter

---
 rtl/led_cnt_pkg.sv | 21 ++
 rtl/key_debounce.sv | 80 ++++++++
 rtl/key_updown_counter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/led_cnt_pkg.sv
// ---------------------------------------------------------------------------
// led_cnt_pkg
// Shared constants for the key-driven up/down LED counter.
//   MODE_WRAP / MODE_SAT : values of the SAT parameter (boundary behaviour)
//   DEF_DEB_CYCLES       : default debounce length (stable samples)
//   cnt_op_e             : per-cycle counter operation after priority decode
// ---------------------------------------------------------------------------
package led_cnt_pkg;

    localparam int MODE_WRAP      = 0;
    localparam int MODE_SAT       = 1;
    localparam int DEF_DEB_CYCLES = 50000;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_CLR  = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } cnt_op_e;

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronises one active-low push-button, debounces it and emits a single
// clk-cycle press pulse on the accepted level's 1->0 transition.
//
// Ports:
//   clk    in   system clock, posedge
//   rst    in   synchronous active-high reset
//   key_n  in   raw key pin, active-low, asynchronous to clk
//   level  out  accepted (debounced) level, 1 = released
//   press  out  one-cycle pulse, registered, on accepted press
//
// Pin-to-press latency: pin low before edge N -> press high after edge
// N+DEB_CYCLES+2, so a consumer registering on press updates at N+DEB_CYCLES+3.
// ---------------------------------------------------------------------------
module key_debounce
    import led_cnt_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             acc_q, acc_d;
    logic             acc_dly_q, acc_dly_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d   = key_n;
        sync2_d   = sync1_q;
        acc_d     = acc_q;
        cnt_d     = '0;
        acc_dly_d = acc_q;
        // Count consecutive synchronised samples that disagree with the
        // accepted level; an agreeing sample clears the run.
        if (sync2_q != acc_q) begin
            if (cnt_q == CNT_LAST) begin
                acc_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Falling edge of the accepted level, seen one cycle late so the
        // pulse comes straight from a flop.
        press_d = acc_dly_q & ~acc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            acc_q     <= 1'b1;
            acc_dly_q <= 1'b1;
            press_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            acc_q     <= acc_d;
            acc_dly_q <= acc_dly_d;
            press_q   <= press_d;
            cnt_q     <= cnt_d;
        end
    end

    assign level = acc_q;
    assign press = press_q;

endmodule

// File: rtl/key_updown_counter.sv
// ---------------------------------------------------------------------------
// key_updown_counter
// Up/down counter driven by three active-low push-buttons, shown on LEDs.
//
// Ports:
//   clk    in   system clock, posedge
//   rst    in   synchronous active-high reset
//   KEY0   in   clear key, active-low, asynchronous
//   KEY1   in   increment key, active-low, asynchronous
//   KEY2   in   decrement key, active-low, asynchronous
//   LEDG   out  [WIDTH-1:0] current count, registered
//   bound  out  one-cycle pulse when an operation wraps (SAT=0) or clips (SAT=1)
//
// Per-cycle priority: clear > (inc and dec together: no-op) > inc > dec.
//
// Optional feature: define KEY_AUTOREPEAT_EN to make held KEY1/KEY2 repeat,
// first REP_DELAY cycles after the press then every REP_PERIOD cycles.
// Without the macro each press gives exactly one event and no repeat
// counters exist.
// ---------------------------------------------------------------------------
module key_updown_counter
    import led_cnt_pkg::*;
#(
    parameter int WIDTH      = 9,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int STEP       = 1,
    parameter int SAT        = MODE_WRAP,
    parameter int REP_DELAY  = 25000000,
    parameter int REP_PERIOD = 5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             KEY0,
    input  logic             KEY1,
    input  logic             KEY2,
    output logic [WIDTH-1:0] LEDG,
    output logic             bound
);

    localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);

    logic lvl_clr, lvl_inc, lvl_dec;
    logic press_clr, press_inc, press_dec;
    logic inc_evt, dec_evt;
    logic unused_sig;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk   (clk),
        .rst   (rst),
        .key_n (KEY0),
        .level (lvl_clr),
        .press (press_clr)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk   (clk),
        .rst   (rst),
        .key_n (KEY1),
        .level (lvl_inc),
        .press (press_inc)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
        .clk   (clk),
        .rst   (rst),
        .key_n (KEY2),
        .level (lvl_dec),
        .press (press_dec)
    );

`ifdef KEY_AUTOREPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REP_PERIOD - 1);

    // Index 0 = increment key, index 1 = decrement key.
    logic [1:0]            rep_arm_q, rep_arm_d;
    logic [1:0]            rep_first_q, rep_first_d;
    logic [1:0][REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [1:0]            rep_fire;
    logic [1:0]            key_lvl, key_press;

    assign key_lvl   = {lvl_dec, lvl_inc};
    assign key_press = {press_dec, press_inc};

    always_comb begin
        rep_arm_d   = rep_arm_q;
        rep_first_d = rep_first_q;
        rep_cnt_d   = rep_cnt_q;
        rep_fire    = '0;
        for (int i = 0; i < 2; i++) begin
            if (press_clr || key_lvl[i]) begin
                // Release or clear ends repetition until the next press.
                rep_arm_d[i] = 1'b0;
                rep_cnt_d[i] = '0;
            end else if (key_press[i]) begin
                rep_arm_d[i]   = 1'b1;
                rep_first_d[i] = 1'b1;
                rep_cnt_d[i]   = '0;
            end else if (rep_arm_q[i]) begin
                if (rep_cnt_q[i] == (rep_first_q[i] ? DELAY_LAST : PERIOD_LAST)) begin
                    rep_fire[i]    = 1'b1;
                    rep_first_d[i] = 1'b0;
                    rep_cnt_d[i]   = '0;
                end else begin
                    rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_arm_q   <= '0;
            rep_first_q <= '0;
            rep_cnt_q   <= '0;
        end else begin
            rep_arm_q   <= rep_arm_d;
            rep_first_q <= rep_first_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end

    assign inc_evt    = press_inc | rep_fire[0];
    assign dec_evt    = press_dec | rep_fire[1];
    assign unused_sig = lvl_clr;
`else
    assign inc_evt    = press_inc;
    assign dec_evt    = press_dec;
    assign unused_sig = ^{lvl_clr, lvl_inc, lvl_dec, REP_DELAY[0], REP_PERIOD[0]};
`endif

    cnt_op_e          op;
    logic [WIDTH:0]   sum_w, diff_w;
    logic [WIDTH-1:0] led_q, led_d;
    logic             bound_q, bound_d;

    always_comb begin
        op = OP_NONE;
        if (press_clr) begin
            op = OP_CLR;
        end else if (inc_evt && dec_evt) begin
            op = OP_NONE;
        end else if (inc_evt) begin
            op = OP_INC;
        end else if (dec_evt) begin
            op = OP_DEC;
        end
    end

    // One extra bit exposes carry-out on increment and borrow on decrement.
    always_comb begin
        sum_w   = {1'b0, led_q} + STEP_W;
        diff_w  = {1'b0, led_q} - STEP_W;
        led_d   = led_q;
        bound_d = 1'b0;
        case (op)
            OP_CLR: begin
                led_d = '0;
            end
            OP_INC: begin
                if (sum_w[WIDTH]) begin
                    bound_d = 1'b1;
                    led_d   = (SAT == MODE_SAT) ? '1 : sum_w[WIDTH-1:0];
                end else begin
                    led_d = sum_w[WIDTH-1:0];
                end
            end
            OP_DEC: begin
                if (diff_w[WIDTH]) begin
                    bound_d = 1'b1;
                    led_d   = (SAT == MODE_SAT) ? '0 : diff_w[WIDTH-1:0];
                end else begin
                    led_d = diff_w[WIDTH-1:0];
                end
            end
            default: begin
                led_d = led_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q   <= '0;
            bound_q <= 1'b0;
        end else begin
            led_q   <= led_d;
            bound_q <= bound_d;
        end
    end

    assign LEDG  = led_q;
    assign bound = bound_q;

endmodule
